// File: rtl/sii9136_int_filter.sv
// ---------------------------------------------------------------------------
// sii9136_int_filter
//
// Deglitches the open-drain, active-low interrupt line of an SiI9136 HDMI
// transmitter before it reaches an edge-capture PIO. The raw pin is brought
// into the clk domain through a flop chain, then a four-state qualifier
// requires the level to be stable for filter_len cycles before the filtered
// output follows it, in both directions. Qualified assertions are counted.
//
// Valid/ready: the Avalon-MM slave has no wait states. A write is accepted in
// any cycle with chipselect=1 and write_n=0. readdata is registered from
// address every cycle, so it is valid one cycle after address is presented,
// whatever chipselect is doing.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   int_n_pin   raw interrupt from the SiI9136 (async, active-low)
//   address     word address: 0 STATUS, 1 FILTER, 2 EVENTS, 3 CONTROL
//   chipselect  slave select
//   write_n     write strobe, active-low
//   writedata   write data
//   readdata    registered read data
//   int_out     filtered interrupt, idle high, low while asserted
// ---------------------------------------------------------------------------
module sii9136_int_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEFAULT_FILTER = 100,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        int_n_pin,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        int_out
);

    typedef enum logic [1:0] {
        IDLE_HI   = 2'd0,
        QUAL_LO   = 2'd1,
        ASSERT_LO = 2'd2,
        QUAL_HI   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_qual_cnt;
    logic                   r_int_out;
    logic [31:0]            r_readdata;
    logic [CNT_W-1:0]       r_filter_len;
    logic [CNT_W-1:0]       r_event_cnt;
    logic                   r_enable;

    logic                   w_sync_n;
    logic                   w_wr;
    logic                   w_wr_filter;
    logic                   w_wr_events;
    logic                   w_wr_ctrl;
    logic                   w_enable_eff;
    logic [CNT_W-1:0]       w_eff_len;
    logic                   w_qual_done;
    logic [CNT_W-1:0]       w_qual_inc;
    logic                   w_event_inc;
    logic [31:0]            w_filter_ext;
    logic [31:0]            w_event_ext;
    logic                   w_unused_wdata;

    // -----------------------------------------------------------------------
    // Synchronizer: only the first flop ever samples the asynchronous pin.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], int_n_pin};
        end
    end

    assign w_sync_n = r_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    assign w_wr        = chipselect && !write_n;
    assign w_wr_filter = w_wr && (address == 2'd1);
    assign w_wr_events = w_wr && (address == 2'd2);
    assign w_wr_ctrl   = w_wr && (address == 2'd3);

    // A CONTROL write acts on the qualifier in the same cycle it is accepted,
    // so disabling forces IDLE_HI at the write edge and re-enabling starts a
    // fresh qualification from IDLE_HI at that same edge.
    assign w_enable_eff = w_wr_ctrl ? writedata[0] : r_enable;

    // A zero filter length would make qualification meaningless; treat as 1.
    assign w_eff_len   = (r_filter_len == '0) ? CNT_ONE : r_filter_len;
    assign w_qual_done = (r_qual_cnt >= w_eff_len);
    assign w_qual_inc  = (r_qual_cnt == '1) ? r_qual_cnt : (r_qual_cnt + CNT_ONE);

    assign w_event_inc = w_enable_eff && (r_state == QUAL_LO) && !w_sync_n && w_qual_done;

    // -----------------------------------------------------------------------
    // Qualifier FSM. int_out is registered alongside the state, taking the
    // output value of the state being entered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE_HI;
            r_qual_cnt <= '0;
            r_int_out  <= 1'b1;
        end else if (!w_enable_eff) begin
            r_state    <= IDLE_HI;
            r_qual_cnt <= '0;
            r_int_out  <= 1'b1;
        end else begin
            case (r_state)
                IDLE_HI: begin
                    r_int_out <= 1'b1;
                    if (!w_sync_n) begin
                        r_state    <= QUAL_LO;
                        r_qual_cnt <= CNT_ONE;
                    end
                end
                QUAL_LO: begin
                    if (w_sync_n) begin
                        r_state <= IDLE_HI;
                    end else if (w_qual_done) begin
                        r_state   <= ASSERT_LO;
                        r_int_out <= 1'b0;
                    end else begin
                        r_qual_cnt <= w_qual_inc;
                    end
                end
                ASSERT_LO: begin
                    r_int_out <= 1'b0;
                    if (w_sync_n) begin
                        r_state    <= QUAL_HI;
                        r_qual_cnt <= CNT_ONE;
                    end
                end
                QUAL_HI: begin
                    if (!w_sync_n) begin
                        r_state <= ASSERT_LO;
                    end else if (w_qual_done) begin
                        r_state   <= IDLE_HI;
                        r_int_out <= 1'b1;
                    end else begin
                        r_qual_cnt <= w_qual_inc;
                    end
                end
                default: begin
                    r_state    <= IDLE_HI;
                    r_qual_cnt <= '0;
                    r_int_out  <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Software registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_filter_len <= CNT_W'(DEFAULT_FILTER);
            r_enable     <= 1'b1;
        end else begin
            if (w_wr_filter) begin
                r_filter_len <= writedata[CNT_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_enable <= writedata[0];
            end
        end
    end

    // A clear that coincides with a new event keeps that event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_event_cnt <= '0;
        end else if (w_wr_events) begin
            r_event_cnt <= w_event_inc ? CNT_ONE : '0;
        end else if (w_event_inc && (r_event_cnt != '1)) begin
            r_event_cnt <= r_event_cnt + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    always_comb begin
        w_filter_ext = '0;
        w_event_ext  = '0;
        w_filter_ext[CNT_W-1:0] = r_filter_len;
        w_event_ext[CNT_W-1:0]  = r_event_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                2'd0:    r_readdata <= {28'd0, r_state, w_sync_n, r_int_out};
                2'd1:    r_readdata <= w_filter_ext;
                2'd2:    r_readdata <= w_event_ext;
                default: r_readdata <= {31'd0, r_enable};
            endcase
        end
    end

    // Write data bits above the implemented fields carry no meaning.
    assign w_unused_wdata = ^writedata;

    assign readdata = r_readdata;
    assign int_out  = r_int_out;

endmodule

// File: tb/tb_sii9136_int_filter.sv
module tb_sii9136_int_filter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        int_n_pin = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        int_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Read scoreboard: expected value and address pushed when a read is issued
    logic [31:0] exp_q[$];
    logic [1:0]  addr_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_sampled = 1'b0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rd_sampled <= rd_issue;
    end

    sii9136_int_filter #(
        .SYNC_STAGES(2),
        .DEFAULT_FILTER(100),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .int_n_pin(int_n_pin),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .int_out(int_out)
    );

    // Scoreboard pop: readdata is valid after the edge that followed the read
    always @(negedge clk) begin
        if (rd_sampled) begin
            logic [31:0] e;
            logic [1:0]  a;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL read_underflow got=%h exp=<queued read>", readdata);
            end else begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (readdata !== e) begin
                    n_errors++;
                    $display("FAIL read_addr%0d got=%h exp=%h", a, readdata, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] e);
        address = a;
        exp_q.push_back(e);
        addr_q.push_back(a);
        rd_issue = 1'b1;
        tick(1);
        rd_issue = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        int_n_pin = 1'b1;
        address   = 2'd1;
        tick(3);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0);
        end
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_int_out got=%b exp=1", int_out);
        end
        reset_n = 1'b1;
        do_read(2'd0, 32'h3);
        do_read(2'd1, 32'd100);
        do_read(2'd2, 32'd0);
        do_read(2'd3, 32'd1);
    endtask

    task automatic test_assert();
        do_write(2'd1, 32'd4);
        int_n_pin = 1'b0;
        tick(6);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL assert_early got=%b exp=1", int_out);
        end
        tick(1);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL assert_latency got=%b exp=0", int_out);
        end
        tick(3);
        int_n_pin = 1'b1;
        tick(6);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL deassert_early got=%b exp=0", int_out);
        end
        tick(1);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL deassert_latency got=%b exp=1", int_out);
        end
        do_read(2'd2, 32'd1);
        do_read(2'd0, 32'h3);
    endtask

    task automatic test_low_glitch();
        int lens[4] = '{1, 2, 3, 4};
        do_write(2'd2, 32'd0);
        foreach (lens[i]) begin
            logic low_seen;
            low_seen  = 1'b0;
            int_n_pin = 1'b0;
            for (int k = 0; k < lens[i] + 10; k++) begin
                if (k == lens[i]) int_n_pin = 1'b1;
                tick(1);
                if (int_out !== 1'b1) low_seen = 1'b1;
            end
            n_checks++;
            if (low_seen !== 1'b0) begin
                n_errors++;
                $display("FAIL low_glitch_%0d got=int_out_low exp=int_out_high", lens[i]);
            end
        end
        do_read(2'd2, 32'd0);
        do_read(2'd0, 32'h3);
    endtask

    task automatic test_high_glitch();
        logic high_seen;
        int_n_pin = 1'b0;
        tick(8);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL hg_asserted got=%b exp=0", int_out);
        end
        do_read(2'd0, 32'h8);
        int_n_pin = 1'b1;
        tick(2);
        int_n_pin = 1'b0;
        high_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (int_out !== 1'b0) high_seen = 1'b1;
        end
        n_checks++;
        if (high_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL high_glitch got=int_out_high exp=int_out_low");
        end
        do_read(2'd0, 32'h8);
        int_n_pin = 1'b1;
        tick(8);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL hg_release got=%b exp=1", int_out);
        end
        do_read(2'd2, 32'd1);
    endtask

    task automatic test_zero_len();
        do_write(2'd1, 32'd0);
        int_n_pin = 1'b0;
        tick(3);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_len_early got=%b exp=1", int_out);
        end
        tick(1);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_len_assert got=%b exp=0", int_out);
        end
        int_n_pin = 1'b1;
        tick(4);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_len_release got=%b exp=1", int_out);
        end
        do_read(2'd1, 32'd0);
        do_read(2'd2, 32'd2);
    endtask

    task automatic test_filter_midqual();
        do_write(2'd1, 32'd20);
        int_n_pin = 1'b0;
        tick(8);
        do_write(2'd1, 32'd3);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL midqual_early got=%b exp=1", int_out);
        end
        tick(1);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL midqual_assert got=%b exp=0", int_out);
        end
        int_n_pin = 1'b1;
        tick(8);
        do_read(2'd2, 32'd3);
    endtask

    task automatic test_back_to_back();
        do_write(2'd1, 32'd4);
        do_write(2'd2, 32'd0);
        for (int k = 0; k < 3; k++) begin
            int_n_pin = 1'b0;
            tick(8);
            int_n_pin = 1'b1;
            tick(8);
        end
        do_read(2'd2, 32'd3);
        int_n_pin = 1'b0;
        tick(6);
        do_write(2'd2, 32'd0);
        n_checks++;
        if (int_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_fourth got=%b exp=0", int_out);
        end
        do_read(2'd2, 32'd1);
    endtask

    task automatic test_enable();
        logic high_lost;
        int   n;
        do_write(2'd3, 32'd0);
        tick(1);
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL disable_int_out got=%b exp=1", int_out);
        end
        do_read(2'd3, 32'd0);
        do_read(2'd0, 32'h1);
        high_lost = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (int_out !== 1'b1) high_lost = 1'b1;
        end
        n_checks++;
        if (high_lost !== 1'b0) begin
            n_errors++;
            $display("FAIL disabled_hold got=int_out_low exp=int_out_high");
        end
        do_write(2'd3, 32'd1);
        n = 0;
        while (int_out === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (int_out !== 1'b0 || n < 2) begin
            n_errors++;
            $display("FAIL reenable_assert got=int_out=%b after %0d cycles exp=0 within 2..19", int_out, n);
        end
        do_read(2'd2, 32'd2);
        int_n_pin = 1'b1;
        tick(8);
    endtask

    task automatic test_reset_mid();
        int r0;
        int n;
        int_n_pin = 1'b0;
        tick(4);
        do_read(2'd0, 32'h5);
        reset_n = 1'b0;
        tick(1);
        r0 = cyc;
        reset_n = 1'b1;
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_int_out got=%b exp=1", int_out);
        end
        do_read(2'd0, 32'h3);
        do_read(2'd1, 32'd100);
        do_read(2'd2, 32'd0);
        do_read(2'd3, 32'd1);
        while (int_out === 1'b1 && (cyc - r0) < 150) tick(1);
        n = cyc - r0;
        n_checks++;
        if (int_out !== 1'b0 || n < 102 || n > 104) begin
            n_errors++;
            $display("FAIL rstmid_requal got=int_out=%b at %0d cycles exp=0 at 102..104", int_out, n);
        end
        do_read(2'd2, 32'd1);
        int_n_pin = 1'b1;
        n = 0;
        while (int_out === 1'b0 && n < 150) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (int_out !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_release got=%b exp=1", int_out);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_assert();
        test_low_glitch();
        test_high_glitch();
        test_zero_len();
        test_filter_midqual();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        tick(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sii9136_int_filter.md
SII9136_INT_FILTER -- requirements
Module: sii9136_int_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on int_n_pin (minimum 2).
REQ-002 Parameter DEFAULT_FILTER, default 100: reset value of the filter length register, in clk cycles.
REQ-003 Parameter CNT_W, default 16: width of the filter length and event counters.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 int_n_pin  input  1  raw open-drain interrupt from the SiI9136; asynchronous to clk; active-low.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  Avalon-MM slave select.
REQ-009 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-010 writedata  input  32  Avalon-MM write data.
REQ-011 readdata  output  32  Avalon-MM read data; registered.
REQ-012 int_out  output  1  filtered level, idle high, low while asserted; drives the downstream edge-capture PIO in_port.

Function
REQ-013 The block SHALL synchronize int_n_pin through SYNC_STAGES flops; the last stage is sync_n. Nothing else samples int_n_pin.
REQ-014 The FSM SHALL have four states: IDLE_HI, QUAL_LO, ASSERT_LO and QUAL_HI.
REQ-015 IDLE_HI: int_out=1. If sync_n=0 and enable=1, go to QUAL_LO and load qual_cnt=1.
REQ-016 QUAL_LO: int_out=1. If sync_n=1, return to IDLE_HI. Otherwise, if qual_cnt>=eff_len, go to ASSERT_LO. Otherwise, increment qual_cnt.
REQ-017 ASSERT_LO: int_out=0. If sync_n=1, go to QUAL_HI and load qual_cnt=1.
REQ-018 QUAL_HI: int_out=0. If sync_n=0, return to ASSERT_LO. Otherwise, if qual_cnt>=eff_len, go to IDLE_HI. Otherwise, increment qual_cnt.
REQ-019 eff_len SHALL equal filter_len; a filter_len of 0 SHALL be treated as 1.
REQ-020 int_out SHALL be a registered output. The latency from an int_n_pin edge to the int_out change is SYNC_STAGES + eff_len + 1 cycles (+-1 for async capture).
REQ-021 A low pulse shorter than eff_len cycles, as seen at sync_n, SHALL NOT change int_out. The same applies to a high glitch while asserted.
REQ-022 qual_cnt SHALL saturate at its all-ones value and SHALL NOT wrap.
REQ-023 A write to filter_len SHALL take effect the next cycle, including mid-qualification. If the current qual_cnt is >= the new eff_len, qualification completes on the next evaluation.
REQ-024 When enable=0: the FSM SHALL go to IDLE_HI within 1 cycle, int_out=1, and qual_cnt is cleared.
REQ-025 When enable goes 0->1 while sync_n=0, qualification SHALL start from IDLE_HI; this yields a fresh assertion.
REQ-026 Each QUAL_LO->ASSERT_LO transition SHALL increment event_cnt, which saturates at 2^CNT_W-1.
REQ-027 On a simultaneous event_cnt clear-write and increment, event_cnt SHALL become 1.
REQ-028 Register map, word addresses; unused bits read 0:
  - 0 STATUS, RO: bit0 = int_out, bit1 = sync_n, bits3:2 = FSM state (IDLE_HI=0, QUAL_LO=1, ASSERT_LO=2, QUAL_HI=3).
  - 1 FILTER, RW: bits CNT_W-1:0 = filter_len.
  - 2 EVENTS: read returns event_cnt; any write clears it.
  - 3 CONTROL, RW: bit0 = enable.
REQ-029 A write SHALL occur when chipselect=1 and write_n=0.
REQ-030 readdata SHALL be updated every cycle from address, giving 1-cycle read latency independent of chipselect.

Reset
REQ-031 With reset_n=0 at a clk edge, the block SHALL apply these values:
  - synchronizer flops = 1
  - FSM = IDLE_HI
  - qual_cnt = 0
  - int_out = 1
  - readdata = 0
  - filter_len = DEFAULT_FILTER
  - event_cnt = 0
  - enable = 1
REQ-032 A reset asserted mid-qualification or during ASSERT_LO SHALL abandon that activity and apply the REQ-031 values. No event is counted.
REQ-033 After reset deassertion with int_n_pin held low, the block SHALL re-qualify. int_out falls after the REQ-020 latency.

Verification
REQ-034 filter_len=4, int_n_pin low for 10 cycles -> int_out low 2+4+1 cycles after the falling edge (+-1); event_cnt reads 1.
REQ-035 filter_len=4, int_n_pin low pulses of 1, 2 and 3 cycles -> int_out stays 1; event_cnt stays 0; STATUS.state returns to 0.
REQ-036 Asserted state, 2-cycle high glitch on int_n_pin with filter_len=4 -> int_out stays 0; state returns to ASSERT_LO.
REQ-037 Drive 3 valid assertions, then write address 2 in the same cycle as the 4th qualification -> event_cnt reads 1.
REQ-038 Write CONTROL=0 while in ASSERT_LO -> int_out=1 the next cycle. Write CONTROL=1 with the pin still low -> int_out falls after the REQ-020 latency; event_cnt increments.
REQ-039 Pulse reset_n low 1 cycle during QUAL_LO -> int_out=1, FILTER reads 100, event_cnt reads 0; readdata shows the new values 1 cycle after each read address.
